pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 24-bit, 4-stage-buffered core: fetch → decode → exec → mem → wb.
- Sequences the exec stage and the stage buffers around it: load-use stalls, branch flushes, multi-cycle memory freezes, and forwarding selects for the exec operand muxes.
- Holds a registered copy of the exec-stage source registers and a saturating stall counter, so it has real sequential state.

Parameters:
- REGW, 4, register-index width (16 registers; index 0 is hardwired zero).
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..3).
- CNTW, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- Ra_d, Rb_d, Rs_d  in  REGW each  decode-stage source indices (Rs = third operand, store data).
- useA, useB, useS  in  1 each  decode instruction reads Ra/Rb/Rs.
- Rc_ex  in  REGW  exec-stage destination.
- regWrite_ex, memToReg_ex  in  1 each  exec-stage write/load flags.
- Rc_mem, regWrite_mem  in  REGW/1  mem-stage destination and write flag.
- Rc_wb, regWrite_wb  in  REGW/1  wb-stage destination and write flag.
- branchFlag_ex  in  1  branch resolved taken in exec this cycle.
- mem_busy  in  1  data memory multi-cycle access in progress.
- en_fetch, en_decode, en_exec, en_mem, en_wb  out  1 each  stage-buffer enables.
- flush_decode, flush_exec  out  1 each  load a bubble (all control bits 0) into that buffer.
- Fa, Fb, Fc  out  2 each  exec operand source: 00 register file, 01 mem-stage result, 10 wb-stage result; 11 never driven.
- stall_count  out  CNTW  cycles spent stalled or frozen, saturating.

Behaviour:
- FSM states: RUN, LDSTALL, FREEZE.
- All outputs are combinational from state, registered exec sources and inputs; a stall takes effect in its detection cycle.
- Reset (rst=1 at posedge):
  - state=RUN, stall counter=0, exec-source copies=0, pending-branch=0.
  - While rst is high: all en_*=0, flush_*=1, Fa/Fb/Fc=00.
  - Reset mid-stall or mid-freeze abandons it.
- RUN:
  - All en_*=1, flush_*=0.
  - Load-use hazard: regWrite_ex & memToReg_ex & Rc_ex≠0 & (useA&Ra_d==Rc_ex | useB&Rb_d==Rc_ex | useS&Rs_d==Rc_ex).
  - On a hazard: en_fetch=en_decode=0, flush_exec=1; counter loads LOAD_STALL-1; go LDSTALL if LOAD_STALL>1, else stay RUN.
- LDSTALL:
  - Same outputs as a hazard cycle.
  - Counter decrements; return to RUN when it reaches 0.
- Branch:
  - branchFlag_ex=1 outside FREEZE: flush_decode=1, flush_exec=1, en_fetch=1 for one cycle.
  - Branch overrides a simultaneous load-use stall and aborts LDSTALL to RUN.
- FREEZE:
  - Entered from any state whenever mem_busy=1 (highest priority).
  - All en_*=0, flush_*=0; exec-source copies and the LDSTALL counter hold.
  - A branchFlag_ex seen while frozen sets pending-branch.
  - When mem_busy drops: return to the pre-freeze state. If pending-branch is set, apply the branch flush in that cycle and clear it.
- Exec-source copies:
  - On en_exec & !flush_exec: copy Ra_d/Rb_d/Rs_d with use flags.
  - On flush_exec: clear use flags.
- Forwarding (per operand):
  - Fx=01 if use & Rx_ex≠0 & regWrite_mem & Rc_mem==Rx_ex.
  - Else Fx=10 if use & Rx_ex≠0 & regWrite_wb & Rc_wb==Rx_ex.
  - Else 00. mem beats wb.
- stall_count increments every cycle with en_decode=0 and rst=0; it saturates at all-ones and never wraps.

Test Plan:
- Reset: rst=1 for 2 cycles → en_*=0, flush_*=1, F*=00, stall_count=0; release → RUN, all en_*=1 next cycle.
- Load-use: exec holds load to R3 (regWrite_ex=1, memToReg_ex=1), decode uses Ra=3 → one cycle en_fetch=en_decode=0, flush_exec=1; next cycle dependent op in exec with load in wb → Fa=10; stall_count=1.
- Forward priority: Ra_ex=5, Rc_mem=5 and Rc_wb=5 both writing → Fa=01; Rc_mem=0 with write → Fa=10; Ra_ex=0 → Fa=00.
- Branch vs stall: load-use hazard and branchFlag_ex=1 same cycle → flush_decode=flush_exec=1, en_fetch=1, no stall; stall_count unchanged.
- Freeze with branch: mem_busy high 3 cycles, branchFlag_ex pulsed in cycle 2 → en_*=0 for 3 cycles, no flush; cycle after release flush_decode=flush_exec=1; stall_count +=3.
- LOAD_STALL=3, rst asserted in 2nd stall cycle → next cycle RUN after reset release, no residual stall; and stall_count forced to all-ones saturates on a further stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freezes and
// exec-stage operand forwarding selects, with a saturating stall performance counter.
module pipe_hazard_ctrl #(
    parameter int unsigned REGW       = 4,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNTW       = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [REGW-1:0] i_ra_d,
    input  logic [REGW-1:0] i_rb_d,
    input  logic [REGW-1:0] i_rs_d,
    input  logic            i_use_a,
    input  logic            i_use_b,
    input  logic            i_use_s,
    input  logic [REGW-1:0] i_rc_ex,
    input  logic            i_reg_write_ex,
    input  logic            i_mem_to_reg_ex,
    input  logic [REGW-1:0] i_rc_mem,
    input  logic            i_reg_write_mem,
    input  logic [REGW-1:0] i_rc_wb,
    input  logic            i_reg_write_wb,
    input  logic            i_branch_flag_ex,
    input  logic            i_mem_busy,
    output logic            o_en_fetch,
    output logic            o_en_decode,
    output logic            o_en_exec,
    output logic            o_en_mem,
    output logic            o_en_wb,
    output logic            o_flush_decode,
    output logic            o_flush_exec,
    output logic [1:0]      o_fa,
    output logic [1:0]      o_fb,
    output logic [1:0]      o_fc,
    output logic [CNTW-1:0] o_stall_count
);

    typedef enum logic [1:0] {StRun, StLdStall, StFreeze} state_e;

    localparam logic [1:0]      LdInit = 2'(LOAD_STALL - 1);
    localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

    state_e          r_state, w_state_next;
    state_e          r_ret_state, w_ret_next;
    state_e          w_eff_state;
    logic [1:0]      r_cnt, w_cnt_next;
    logic            r_pend_br, w_pend_next;
    logic [CNTW-1:0] r_stall_count;
    logic [REGW-1:0] r_ra_ex, r_rb_ex, r_rs_ex;
    logic            r_use_a_ex, r_use_b_ex, r_use_s_ex;
    logic            w_hazard, w_branch;

    function automatic logic [1:0] fwd_sel(
        input logic            use_x,
        input logic [REGW-1:0] rx,
        input logic            wr_mem,
        input logic [REGW-1:0] rc_mem,
        input logic            wr_wb,
        input logic [REGW-1:0] rc_wb
    );
        if (!use_x || rx == '0) return 2'b00;
        if (wr_mem && rc_mem == rx) return 2'b01;
        if (wr_wb && rc_wb == rx) return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        // The release cycle of a freeze behaves as the state that was frozen.
        w_eff_state = (r_state == StFreeze) ? r_ret_state : r_state;
        w_branch    = i_branch_flag_ex | ((r_state == StFreeze) & r_pend_br);
        w_hazard    = i_reg_write_ex & i_mem_to_reg_ex & (i_rc_ex != '0) &
                      ((i_use_a & (i_ra_d == i_rc_ex)) |
                       (i_use_b & (i_rb_d == i_rc_ex)) |
                       (i_use_s & (i_rs_d == i_rc_ex)));

        w_state_next   = w_eff_state;
        w_ret_next     = r_ret_state;
        w_cnt_next     = r_cnt;
        w_pend_next    = r_pend_br;
        o_en_fetch     = 1'b1;
        o_en_decode    = 1'b1;
        o_en_exec      = 1'b1;
        o_en_mem       = 1'b1;
        o_en_wb        = 1'b1;
        o_flush_decode = 1'b0;
        o_flush_exec   = 1'b0;

        if (i_mem_busy) begin
            o_en_fetch   = 1'b0;
            o_en_decode  = 1'b0;
            o_en_exec    = 1'b0;
            o_en_mem     = 1'b0;
            o_en_wb      = 1'b0;
            w_state_next = StFreeze;
            w_ret_next   = w_eff_state;
            w_pend_next  = r_pend_br | i_branch_flag_ex;
        end else begin
            w_pend_next = 1'b0;
            if (w_branch) begin
                o_flush_decode = 1'b1;
                o_flush_exec   = 1'b1;
                w_state_next   = StRun;
            end else if (w_eff_state == StLdStall) begin
                o_en_fetch   = 1'b0;
                o_en_decode  = 1'b0;
                o_flush_exec = 1'b1;
                w_cnt_next   = r_cnt - 2'd1;
                w_state_next = (r_cnt == 2'd1) ? StRun : StLdStall;
            end else if (w_hazard) begin
                o_en_fetch   = 1'b0;
                o_en_decode  = 1'b0;
                o_flush_exec = 1'b1;
                w_cnt_next   = LdInit;
                w_state_next = (LOAD_STALL > 1) ? StLdStall : StRun;
            end
        end

        if (i_rst) begin
            o_en_fetch     = 1'b0;
            o_en_decode    = 1'b0;
            o_en_exec      = 1'b0;
            o_en_mem       = 1'b0;
            o_en_wb        = 1'b0;
            o_flush_decode = 1'b1;
            o_flush_exec   = 1'b1;
        end
    end

    always_comb begin
        o_fa = 2'b00;
        o_fb = 2'b00;
        o_fc = 2'b00;
        if (!i_rst) begin
            o_fa = fwd_sel(r_use_a_ex, r_ra_ex, i_reg_write_mem, i_rc_mem,
                           i_reg_write_wb, i_rc_wb);
            o_fb = fwd_sel(r_use_b_ex, r_rb_ex, i_reg_write_mem, i_rc_mem,
                           i_reg_write_wb, i_rc_wb);
            o_fc = fwd_sel(r_use_s_ex, r_rs_ex, i_reg_write_mem, i_rc_mem,
                           i_reg_write_wb, i_rc_wb);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StRun;
            r_ret_state   <= StRun;
            r_cnt         <= '0;
            r_pend_br     <= 1'b0;
            r_stall_count <= '0;
            r_ra_ex       <= '0;
            r_rb_ex       <= '0;
            r_rs_ex       <= '0;
            r_use_a_ex    <= 1'b0;
            r_use_b_ex    <= 1'b0;
            r_use_s_ex    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ret_state <= w_ret_next;
            r_cnt       <= w_cnt_next;
            r_pend_br   <= w_pend_next;
            if (!o_en_decode && r_stall_count != '1) begin
                r_stall_count <= r_stall_count + CntOne;
            end
            if (o_flush_exec) begin
                r_use_a_ex <= 1'b0;
                r_use_b_ex <= 1'b0;
                r_use_s_ex <= 1'b0;
            end else if (o_en_exec) begin
                r_ra_ex    <= i_ra_d;
                r_rb_ex    <= i_rb_d;
                r_rs_ex    <= i_rs_d;
                r_use_a_ex <= i_use_a;
                r_use_b_ex <= i_use_b;
                r_use_s_ex <= i_use_s;
            end
        end
    end

    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand sequences on a LOAD_STALL=3 /
// 3-bit-counter instance, and random stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [3:0] ra, rb, rs;
        logic       ua, ub, us;
        logic [3:0] rc_ex;
        logic       rw_ex, m2r_ex;
        logic [3:0] rc_mem;
        logic       rw_mem;
        logic [3:0] rc_wb;
        logic       rw_wb;
        logic       br, busy;
    } in_t;

    typedef struct {
        in_t         vi;
        logic [12:0] exp_o;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        int         left;
        bit         pend;
        int         cnt;
        logic [3:0] ra, rb, rs;
        bit         ua, ub, us;
    } mdl_t;

    // {en_fetch..en_wb, flush_decode, flush_exec, fa, fb, fc}
    localparam logic [12:0] O_RUN   = 13'b11111_00_000000;
    localparam logic [12:0] O_RST   = 13'b00000_11_000000;
    localparam logic [12:0] O_STALL = 13'b00111_01_000000;
    localparam logic [12:0] O_BR    = 13'b11111_11_000000;
    localparam logic [12:0] O_FRZ   = 13'b00000_00_000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t din;
    logic [4:0]  en1, en3;
    logic        fd1, fe1, fd3, fe3;
    logic [1:0]  fa1, fb1, fc1, fa3, fb3, fc3;
    logic [15:0] cnt1;
    logic [2:0]  cnt3;
    logic [12:0] o1, o3;

    assign o1 = {en1, fd1, fe1, fa1, fb1, fc1};
    assign o3 = {en3, fd3, fe3, fa3, fb3, fc3};

    pipe_hazard_ctrl #(.REGW(4), .LOAD_STALL(1), .CNTW(16)) u_dut (
        .i_clk(clk), .i_rst(din.rst),
        .i_ra_d(din.ra), .i_rb_d(din.rb), .i_rs_d(din.rs),
        .i_use_a(din.ua), .i_use_b(din.ub), .i_use_s(din.us),
        .i_rc_ex(din.rc_ex), .i_reg_write_ex(din.rw_ex), .i_mem_to_reg_ex(din.m2r_ex),
        .i_rc_mem(din.rc_mem), .i_reg_write_mem(din.rw_mem),
        .i_rc_wb(din.rc_wb), .i_reg_write_wb(din.rw_wb),
        .i_branch_flag_ex(din.br), .i_mem_busy(din.busy),
        .o_en_fetch(en1[4]), .o_en_decode(en1[3]), .o_en_exec(en1[2]),
        .o_en_mem(en1[1]), .o_en_wb(en1[0]),
        .o_flush_decode(fd1), .o_flush_exec(fe1),
        .o_fa(fa1), .o_fb(fb1), .o_fc(fc1), .o_stall_count(cnt1)
    );

    pipe_hazard_ctrl #(.REGW(4), .LOAD_STALL(3), .CNTW(3)) u_dut3 (
        .i_clk(clk), .i_rst(din.rst),
        .i_ra_d(din.ra), .i_rb_d(din.rb), .i_rs_d(din.rs),
        .i_use_a(din.ua), .i_use_b(din.ub), .i_use_s(din.us),
        .i_rc_ex(din.rc_ex), .i_reg_write_ex(din.rw_ex), .i_mem_to_reg_ex(din.m2r_ex),
        .i_rc_mem(din.rc_mem), .i_reg_write_mem(din.rw_mem),
        .i_rc_wb(din.rc_wb), .i_reg_write_wb(din.rw_wb),
        .i_branch_flag_ex(din.br), .i_mem_busy(din.busy),
        .o_en_fetch(en3[4]), .o_en_decode(en3[3]), .o_en_exec(en3[2]),
        .o_en_mem(en3[1]), .o_en_wb(en3[0]),
        .o_flush_decode(fd3), .o_flush_exec(fe3),
        .o_fa(fa3), .o_fb(fb3), .o_fc(fc3), .o_stall_count(cnt3)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    mdl_t m1, m3;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] mfwd(input bit u, input logic [3:0] r, input in_t v);
        if (u && r != 4'd0) begin
            if (v.rw_mem && v.rc_mem == r) return 2'b01;
            if (v.rw_wb && v.rc_wb == r) return 2'b10;
        end
        return 2'b00;
    endfunction

    // One clock of the reference: returns next model state, expected outputs via o.
    function automatic mdl_t mdl_step(input mdl_t m, input in_t v, input int lds,
                                      input int cmax, output logic [12:0] o);
        mdl_t       n;
        logic [4:0] en;
        logic       fd, fe;
        bit         haz;
        n   = m;
        en  = 5'b11111;
        fd  = 1'b0;
        fe  = 1'b0;
        haz = v.rw_ex && v.m2r_ex && v.rc_ex != 4'd0 &&
              ((v.ua && v.ra == v.rc_ex) || (v.ub && v.rb == v.rc_ex) ||
               (v.us && v.rs == v.rc_ex));
        if (v.rst) begin
            o = O_RST;
            n = '{default: 0};
            return n;
        end
        if (v.busy) begin
            en     = 5'b00000;
            n.pend = m.pend | v.br;
        end else begin
            n.pend = 1'b0;
            if (v.br || m.pend) begin
                fd     = 1'b1;
                fe     = 1'b1;
                n.left = 0;
            end else if (m.left > 0) begin
                en[4:3] = 2'b00;
                fe      = 1'b1;
                n.left  = m.left - 1;
            end else if (haz) begin
                en[4:3] = 2'b00;
                fe      = 1'b1;
                n.left  = lds - 1;
            end
        end
        if (!en[3] && m.cnt < cmax) n.cnt = m.cnt + 1;
        if (fe) begin
            n.ua = 0; n.ub = 0; n.us = 0;
        end else if (en[2]) begin
            n.ra = v.ra; n.rb = v.rb; n.rs = v.rs;
            n.ua = v.ua; n.ub = v.ub; n.us = v.us;
        end
        o = {en, fd, fe, mfwd(m.ua, m.ra, v), mfwd(m.ub, m.rb, v), mfwd(m.us, m.rs, v)};
        return n;
    endfunction

    // Drive one cycle; always checks both instances against the model, and optionally
    // checks one instance against fixed constants (e_cnt < 0 skips the counter).
    task automatic apply(input in_t v, input bit on3, input bit has_exp,
                         input logic [12:0] e_o, input int e_cnt);
        logic [12:0] p1, p3;
        mdl_t        n1, n3;
        din = v;
        @(negedge clk);
        n1 = mdl_step(m1, v, 1, 65535, p1);
        n3 = mdl_step(m3, v, 3, 7, p3);
        chk("model_out_ls1", 32'(o1), 32'(p1));
        chk("model_cnt_ls1", 32'(cnt1), 32'(m1.cnt));
        chk("model_out_ls3", 32'(o3), 32'(p3));
        chk("model_cnt_ls3", 32'(cnt3), 32'(m3.cnt));
        if (has_exp) begin
            if (on3) begin
                chk("vec_out_ls3", 32'(o3), 32'(e_o));
                if (e_cnt >= 0) chk("vec_cnt_ls3", 32'(cnt3), 32'(e_cnt));
            end else begin
                chk("vec_out_ls1", 32'(o1), 32'(e_o));
                if (e_cnt >= 0) chk("vec_cnt_ls1", 32'(cnt1), 32'(e_cnt));
            end
        end
        @(posedge clk);
        m1 = n1;
        m3 = n3;
        cyc++;
        #1;
    endtask

    task automatic add(input in_t v, input logic [12:0] o, input int c);
        vec_t e;
        e.vi = v; e.exp_o = o; e.exp_cnt = c;
        tbl.push_back(e);
    endtask

    function automatic in_t haz_in();
        in_t v;
        v = '0;
        v.rc_ex = 4'd3; v.rw_ex = 1'b1; v.m2r_ex = 1'b1;
        v.ra = 4'd3; v.ua = 1'b1;
        return v;
    endfunction

    initial begin
        in_t v;
        m1  = '{default: 0};
        m3  = '{default: 0};
        din = '0;
        din.rst = 1'b1;

        v = '0; v.rst = 1'b1;
        add(v, O_RST, 0);
        add(v, O_RST, 0);
        v = '0;            add(v, O_RUN, 0);
        v = haz_in();      add(v, O_STALL, 0);
        v = '0; v.ra = 4'd3; v.ua = 1'b1; v.rc_mem = 4'd3; v.rw_mem = 1'b1;
        add(v, O_RUN, 1);
        v = '0; v.rc_wb = 4'd3; v.rw_wb = 1'b1;
        add(v, O_RUN | 13'h020, 1);
        v = '0; v.ra = 4'd5; v.rb = 4'd6; v.rs = 4'd7; v.ua = 1; v.ub = 1; v.us = 1;
        add(v, O_RUN, 1);
        v.rc_mem = 4'd5; v.rw_mem = 1'b1; v.rc_wb = 4'd5; v.rw_wb = 1'b1;
        add(v, O_RUN | 13'h010, 1);
        v.rc_mem = 4'd0;
        add(v, O_RUN | 13'h020, 1);
        v.ra = 4'd0; v.rc_mem = 4'd6; v.rw_mem = 1'b0; v.rc_wb = 4'd6;
        add(v, O_RUN | 13'h008, 1);
        v = '0; v.rw_mem = 1'b1; v.rw_wb = 1'b1;
        add(v, O_RUN, 1);
        v = haz_in(); v.br = 1'b1; add(v, O_BR, 1);
        v = '0;                    add(v, O_RUN, 1);
        v = '0; v.busy = 1'b1;     add(v, O_FRZ, 1);
        v.br = 1'b1;               add(v, O_FRZ, 2);
        v.br = 1'b0;               add(v, O_FRZ, 3);
        v = '0;                    add(v, O_BR, 4);
        add(v, O_RUN, 4);
        v = haz_in(); v.busy = 1'b1; add(v, O_FRZ, 4);
        v = haz_in();              add(v, O_STALL, 5);
        v = '0;                    add(v, O_RUN, 6);
        add(v, O_RUN, 6);

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i].vi, 1'b0, 1'b1, tbl[i].exp_o, tbl[i].exp_cnt);

        // LOAD_STALL=3: reset in the second stall cycle leaves no residual stall.
        apply(haz_in(), 1'b1, 1'b1, O_STALL, -1);
        v = '0; v.rst = 1'b1;
        apply(v, 1'b1, 1'b1, O_RST, -1);
        v = '0;
        apply(v, 1'b1, 1'b1, O_RUN, 0);
        apply(v, 1'b1, 1'b1, O_RUN, 0);

        // 3-bit counter saturates at 7 through a freeze and a following load stall.
        v = '0; v.busy = 1'b1;
        for (int i = 0; i < 9; i++) apply(v, 1'b1, 1'b1, O_FRZ, (i > 7) ? 7 : i);
        apply(haz_in(), 1'b1, 1'b1, O_STALL, 7);
        v = '0;
        apply(v, 1'b1, 1'b1, O_STALL, 7);
        apply(v, 1'b1, 1'b1, O_STALL, 7);
        apply(v, 1'b1, 1'b1, O_RUN, 7);

        for (int i = 0; i < 3000; i++) begin
            v        = '0;
            v.rst    = ($urandom_range(0, 63) == 0);
            v.busy   = ($urandom_range(0, 7) == 0);
            v.br     = ($urandom_range(0, 9) == 0);
            v.ra     = 4'($urandom_range(0, 4));
            v.rb     = 4'($urandom_range(0, 4));
            v.rs     = 4'($urandom_range(0, 4));
            v.ua     = 1'($urandom);
            v.ub     = 1'($urandom);
            v.us     = 1'($urandom);
            v.rc_ex  = 4'($urandom_range(0, 4));
            v.rw_ex  = 1'($urandom);
            v.m2r_ex = 1'($urandom);
            v.rc_mem = 4'($urandom_range(0, 4));
            v.rw_mem = 1'($urandom);
            v.rc_wb  = 4'($urandom_range(0, 4));
            v.rw_wb  = 1'($urandom);
            apply(v, 1'b0, 1'b0, O_FRZ, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
